// File: rtl/fifo_param_pkg.sv
// Shared definitions for the parametrised FIFO: depth/count-width rules,
// read-mode constants and the status-flag bundle.
package fifo_param_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostFull;
    logic almostEmpty;
  } fifo_status_t;

  function automatic int fifoDepth(input int addrWidth);
    return 1 << addrWidth;
  endfunction

  // The count must hold DEPTH itself, so it needs one bit more than a pointer.
  function automatic int cntWidth(input int addrWidth);
    return addrWidth + 1;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer-facing bundle of the FIFO: push, pop, thresholds, status and errors.
interface fifo_param_if
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) ();

  logic                               wr_en;
  logic [DATA_WIDTH-1:0]              wr_data;
  logic                               rd_en;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic                               rd_valid;
  logic [cntWidth(ADDR_WIDTH)-1:0]    umb_almost_full;
  logic [cntWidth(ADDR_WIDTH)-1:0]    umb_almost_empty;
  logic                               full;
  logic                               empty;
  logic                               almost_full;
  logic                               almost_empty;
  logic [cntWidth(ADDR_WIDTH)-1:0]    data_count;
  logic                               overflow_err;
  logic                               underflow_err;
  logic                               err_clr;

  modport master (
    output wr_en, wr_data, rd_en, umb_almost_full, umb_almost_empty, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           data_count, overflow_err, underflow_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en, umb_almost_full, umb_almost_empty, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           data_count, overflow_err, underflow_err
  );

endinterface

// File: rtl/fifo_dp_ram.sv
// Storage array for the FIFO: synchronous write port, asynchronous read port.
module fifo_dp_ram #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents are never reset; the pointers alone decide which words are live.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with standard or first-word-fall-through reads,
// full 0..DEPTH count, threshold flags and sticky overflow/underflow errors.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input  logic        clk,
  input  logic        reset,
  fifo_param_if.slave bus
);

  localparam int DEPTH = fifoDepth(ADDR_WIDTH);
  localparam int CNT_W = cntWidth(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wrOk;
  logic                  rdOk;
  logic [DATA_WIDTH-1:0] ramRdata;
  fifo_status_t          status;

  // Flags follow the registered count and the live thresholds.
  always_comb begin
    status.full        = (count_q == CNT_W'(DEPTH));
    status.empty       = (count_q == '0);
    status.almostFull  = (count_q >= bus.umb_almost_full);
    status.almostEmpty = !status.empty && (count_q <= bus.umb_almost_empty);
  end

  // A push into a full FIFO is still fine when a pop frees the slot the same edge.
  assign rdOk = bus.rd_en & ~status.empty;
  assign wrOk = bus.wr_en & (~status.full | rdOk);

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~bus.err_clr;
    underflow_d = underflow_q & ~bus.err_clr;
    if (wrOk) begin
      wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
    end
    if (rdOk) begin
      rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
    end
    if (wrOk && !rdOk) begin
      count_d = count_q + CNT_W'(1);
    end else if (rdOk && !wrOk) begin
      count_d = count_q - CNT_W'(1);
    end
    if (bus.wr_en && status.full && !rdOk) begin
      overflow_d = 1'b1;
    end
    if (bus.rd_en && status.empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) uRam (
    .clk_i   (clk),
    .we_i    (wrOk),
    .waddr_i (wrPtr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rdPtr_q),
    .rdata_o (ramRdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : gFwft
      assign bus.rd_data  = ramRdata;
      assign bus.rd_valid = ~status.empty;
    end else begin : gStd
      logic [DATA_WIDTH-1:0] rdData_q;
      logic                  rdValid_q;

      // Popped word is captured at the accepting edge and held until the next pop.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdData_q  <= '0;
          rdValid_q <= 1'b0;
        end else begin
          rdValid_q <= rdOk;
          if (rdOk) begin
            rdData_q <= ramRdata;
          end
        end
      end

      assign bus.rd_data  = rdData_q;
      assign bus.rd_valid = rdValid_q;
    end
  endgenerate

  assign bus.full          = status.full;
  assign bus.empty         = status.empty;
  assign bus.almost_full   = status.almostFull;
  assign bus.almost_empty  = status.almostEmpty;
  assign bus.data_count    = count_q;
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: standard, FWFT and 8x16 builds checked against a queue model.
module tb_fifo_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nTests = 0;
  int   nFail = 0;

  fifo_param_if #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) busStd ();
  fifo_param_if #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) busFw ();
  fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) busWide ();

  fifo_param #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .FWFT(0)) dutStd (
    .clk(clk), .reset(reset), .bus(busStd));
  fifo_param #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .FWFT(1)) dutFw (
    .clk(clk), .reset(reset), .bus(busFw));
  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dutWide (
    .clk(clk), .reset(reset), .bus(busWide));

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge, outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    busStd.wr_en = 0;  busStd.rd_en = 0;  busStd.err_clr = 0;  busStd.wr_data = 0;
    busStd.umb_almost_full = 4'd6;  busStd.umb_almost_empty = 4'd2;
    busFw.wr_en = 0;   busFw.rd_en = 0;   busFw.err_clr = 0;   busFw.wr_data = 0;
    busFw.umb_almost_full = 4'd6;   busFw.umb_almost_empty = 4'd2;
    busWide.wr_en = 0; busWide.rd_en = 0; busWide.err_clr = 0; busWide.wr_data = 0;
    busWide.umb_almost_full = 5'd12; busWide.umb_almost_empty = 5'd3;
  endtask

  task automatic doReset();
    idleAll();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idleAll();
    reset = 1'b1;
    #2;
    nTests++;
    if ({busStd.full, busStd.empty, busStd.almost_full, busStd.almost_empty, busStd.rd_valid,
         busStd.overflow_err, busStd.underflow_err} !== 7'b0100000) begin
      nFail++;
      $display("[TB] FAIL reset_flags: got %b expected 0100000",
               {busStd.full, busStd.empty, busStd.almost_full, busStd.almost_empty,
                busStd.rd_valid, busStd.overflow_err, busStd.underflow_err});
    end
    nTests++;
    if ({busStd.data_count, busStd.rd_data} !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL reset_count_data: got %h expected 00", {busStd.data_count, busStd.rd_data});
    end
    nTests++;
    if ({busFw.rd_valid, busFw.empty} !== 2'b01) begin
      nFail++;
      $display("[TB] FAIL reset_fwft: got %b expected 01", {busFw.rd_valid, busFw.empty});
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_fill();
    doReset();
    for (int i = 1; i <= 8; i++) begin
      busStd.wr_en = 1; busStd.wr_data = 4'(i);
      tick();
      nTests++;
      if ({busStd.data_count, busStd.almost_empty, busStd.almost_full, busStd.full} !==
          {4'(i), 1'(i <= 2), 1'(i >= 6), 1'(i == 8)}) begin
        nFail++;
        $display("[TB] FAIL fill_step%0d: got %b expected %b", i,
                 {busStd.data_count, busStd.almost_empty, busStd.almost_full, busStd.full},
                 {4'(i), 1'(i <= 2), 1'(i >= 6), 1'(i == 8)});
      end
    end
    busStd.wr_data = 4'h9;
    tick();
    busStd.wr_en = 0;
    nTests++;
    if ({busStd.overflow_err, busStd.data_count} !== {1'b1, 4'd8}) begin
      nFail++;
      $display("[TB] FAIL fill_overflow: got %b expected 11000", {busStd.overflow_err, busStd.data_count});
    end
    for (int k = 1; k <= 8; k++) begin
      busStd.rd_en = 1;
      tick();
      nTests++;
      if ({busStd.rd_valid, busStd.rd_data} !== {1'b1, 4'(k)}) begin
        nFail++;
        $display("[TB] FAIL fill_pop%0d: got %b expected %b", k,
                 {busStd.rd_valid, busStd.rd_data}, {1'b1, 4'(k)});
      end
    end
    busStd.rd_en = 0;
    tick();
    nTests++;
    if ({busStd.rd_valid, busStd.empty, busStd.rd_data} !== {2'b01, 4'h8}) begin
      nFail++;
      $display("[TB] FAIL fill_drained: got %b expected 011000",
               {busStd.rd_valid, busStd.empty, busStd.rd_data});
    end
  endtask

  task automatic test_underflow();
    busStd.rd_en = 1;
    tick();
    busStd.rd_en = 0;
    nTests++;
    if ({busStd.underflow_err, busStd.rd_valid, busStd.data_count} !== {2'b10, 4'd0}) begin
      nFail++;
      $display("[TB] FAIL underflow_set: got %b expected 100000",
               {busStd.underflow_err, busStd.rd_valid, busStd.data_count});
    end
    busStd.err_clr = 1;
    tick();
    nTests++;
    if ({busStd.underflow_err, busStd.overflow_err} !== 2'b00) begin
      nFail++;
      $display("[TB] FAIL err_clear: got %b expected 00", {busStd.underflow_err, busStd.overflow_err});
    end
    busStd.rd_en = 1;
    tick();
    busStd.rd_en = 0;
    nTests++;
    if (busStd.underflow_err !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL clr_vs_set: got %b expected 1", busStd.underflow_err);
    end
    tick();
    busStd.err_clr = 0;
  endtask

  task automatic test_full_pushpop();
    doReset();
    for (int i = 1; i <= 8; i++) begin
      busStd.wr_en = 1; busStd.wr_data = 4'(i);
      tick();
    end
    busStd.wr_data = 4'h9; busStd.rd_en = 1;
    tick();
    busStd.wr_en = 0;
    nTests++;
    if ({busStd.rd_valid, busStd.rd_data, busStd.data_count, busStd.overflow_err} !==
        {1'b1, 4'h1, 4'd8, 1'b0}) begin
      nFail++;
      $display("[TB] FAIL full_pushpop: got %b expected 1000110000",
               {busStd.rd_valid, busStd.rd_data, busStd.data_count, busStd.overflow_err});
    end
    for (int k = 2; k <= 9; k++) begin
      tick();
      nTests++;
      if ({busStd.rd_valid, busStd.rd_data} !== {1'b1, 4'(k)}) begin
        nFail++;
        $display("[TB] FAIL wrap_pop%0d: got %b expected %b", k,
                 {busStd.rd_valid, busStd.rd_data}, {1'b1, 4'(k)});
      end
    end
    busStd.rd_en = 0;
    tick();
  endtask

  task automatic test_fwft();
    doReset();
    busFw.wr_en = 1; busFw.wr_data = 4'hA;
    #1;
    nTests++;
    if (busFw.rd_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL fwft_before: got %b expected 0", busFw.rd_valid);
    end
    tick();
    busFw.wr_en = 0;
    nTests++;
    if ({busFw.rd_valid, busFw.rd_data} !== 5'b11010) begin
      nFail++;
      $display("[TB] FAIL fwft_head: got %b expected 11010", {busFw.rd_valid, busFw.rd_data});
    end
    busFw.rd_en = 1;
    tick();
    busFw.rd_en = 0;
    nTests++;
    if ({busFw.empty, busFw.rd_valid, busFw.underflow_err} !== 3'b100) begin
      nFail++;
      $display("[TB] FAIL fwft_ack: got %b expected 100", {busFw.empty, busFw.rd_valid, busFw.underflow_err});
    end
  endtask

  task automatic test_async_reset();
    doReset();
    for (int i = 0; i < 6; i++) begin
      busStd.wr_en = 1; busStd.wr_data = 4'($urandom_range(1, 15));
      tick();
    end
    busStd.wr_en = 0; busStd.rd_en = 1;
    tick();
    busStd.rd_en = 0;
    nTests++;
    if ({busStd.data_count, busStd.rd_valid} !== {4'd5, 1'b1}) begin
      nFail++;
      $display("[TB] FAIL pre_reset: got %b expected 01011", {busStd.data_count, busStd.rd_valid});
    end
    #1;
    reset = 1'b1;
    #1;
    nTests++;
    if ({busStd.data_count, busStd.rd_data, busStd.full, busStd.empty, busStd.almost_full,
         busStd.almost_empty, busStd.rd_valid} !== {8'h00, 5'b01000}) begin
      nFail++;
      $display("[TB] FAIL async_reset: got %b expected 0000000001000",
               {busStd.data_count, busStd.rd_data, busStd.full, busStd.empty,
                busStd.almost_full, busStd.almost_empty, busStd.rd_valid});
    end
    tick();
    reset = 1'b0;
    busStd.wr_en = 1; busStd.wr_data = 4'h3;
    tick();
    busStd.wr_en = 0; busStd.rd_en = 1;
    tick();
    busStd.rd_en = 0;
    nTests++;
    if ({busStd.rd_valid, busStd.rd_data, busStd.data_count} !== {1'b1, 4'h3, 4'd0}) begin
      nFail++;
      $display("[TB] FAIL post_reset_word: got %b expected 100110000",
               {busStd.rd_valid, busStd.rd_data, busStd.data_count});
    end
  endtask

  task automatic test_wide();
    logic [7:0] wq[$];
    logic [7:0] d;
    doReset();
    for (int i = 1; i <= 16; i++) begin
      d = 8'($urandom);
      wq.push_back(d);
      busWide.wr_en = 1; busWide.wr_data = d;
      tick();
      nTests++;
      if ({busWide.data_count, busWide.full, busWide.almost_full} !==
          {5'(i), 1'(i == 16), 1'(i >= 12)}) begin
        nFail++;
        $display("[TB] FAIL wide_fill%0d: got %b expected %b", i,
                 {busWide.data_count, busWide.full, busWide.almost_full},
                 {5'(i), 1'(i == 16), 1'(i >= 12)});
      end
    end
    busWide.wr_data = 8'hEE;
    tick();
    busWide.wr_en = 0;
    nTests++;
    if ({busWide.overflow_err, busWide.data_count} !== {1'b1, 5'd16}) begin
      nFail++;
      $display("[TB] FAIL wide_overflow: got %b expected 110000", {busWide.overflow_err, busWide.data_count});
    end
    for (int k = 0; k < 16; k++) begin
      busWide.rd_en = 1;
      tick();
      d = wq.pop_front();
      nTests++;
      if ({busWide.rd_valid, busWide.rd_data} !== {1'b1, d}) begin
        nFail++;
        $display("[TB] FAIL wide_pop%0d: got %h expected %h", k, {busWide.rd_valid, busWide.rd_data}, {1'b1, d});
      end
    end
    busWide.rd_en = 0;
  endtask

  // Same random traffic drives the standard and FWFT builds against one queue model.
  task automatic test_random();
    logic [3:0] q[$];
    logic [3:0] lastStd;
    logic [3:0] expFlags;
    bit ovM, unM, we, re, ec, rOk, wOk;
    int af, ae, cnt;
    logic [3:0] d;
    doReset();
    lastStd = 4'h0; ovM = 0; unM = 0;
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      ec = ($urandom_range(0, 99) < 6);
      d  = 4'($urandom);
      af = $urandom_range(0, 9);
      ae = $urandom_range(0, 9);
      busStd.wr_en = we; busStd.rd_en = re; busStd.err_clr = ec; busStd.wr_data = d;
      busStd.umb_almost_full = 4'(af); busStd.umb_almost_empty = 4'(ae);
      busFw.wr_en = we;  busFw.rd_en = re;  busFw.err_clr = ec;  busFw.wr_data = d;
      busFw.umb_almost_full = 4'(af);  busFw.umb_almost_empty = 4'(ae);
      rOk = re && (q.size() > 0);
      wOk = we && ((q.size() < 8) || rOk);
      ovM = (ovM && !ec) || (we && q.size() == 8 && !rOk);
      unM = (unM && !ec) || (re && q.size() == 0);
      if (rOk) lastStd = q.pop_front();
      if (wOk) q.push_back(d);
      tick();
      cnt = q.size();
      expFlags = {1'(cnt == 8), 1'(cnt == 0), 1'(cnt >= af), 1'(cnt != 0 && cnt <= ae)};
      nTests++;
      if ({busStd.data_count, busStd.full, busStd.empty, busStd.almost_full, busStd.almost_empty,
           busStd.rd_valid, busStd.rd_data, busStd.overflow_err, busStd.underflow_err} !==
          {4'(cnt), expFlags, rOk, lastStd, ovM, unM}) begin
        nFail++;
        $display("[TB] FAIL rand_std%0d: got %b expected %b", n,
                 {busStd.data_count, busStd.full, busStd.empty, busStd.almost_full,
                  busStd.almost_empty, busStd.rd_valid, busStd.rd_data,
                  busStd.overflow_err, busStd.underflow_err},
                 {4'(cnt), expFlags, rOk, lastStd, ovM, unM});
      end
      nTests++;
      if ({busFw.data_count, busFw.rd_valid, busFw.overflow_err, busFw.underflow_err} !==
          {4'(cnt), 1'(cnt != 0), ovM, unM} ||
          (cnt != 0 && busFw.rd_data !== q[0])) begin
        nFail++;
        $display("[TB] FAIL rand_fwft%0d: got %b/%h expected %b/%h", n,
                 {busFw.data_count, busFw.rd_valid, busFw.overflow_err, busFw.underflow_err},
                 busFw.rd_data, {4'(cnt), 1'(cnt != 0), ovM, unM}, (cnt != 0) ? q[0] : 4'h0);
      end
    end
    idleAll();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_underflow();
    test_full_pushpop();
    test_fwft();
    test_async_reset();
    test_wide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
